seg7_scan_mux: RTL and testbench

Parametrised, time-multiplexed seven-segment display driver for the board's common-anode displays. It scans `DIGITS` hex digits at a programmable refresh rate and adds features a fixed 4-digit scanner lacks:
- per-digit decimal points;
- leading-zero suppression;
- 16-level PWM brightness;
- a double-buffered load port so the displayed value never tears mid-frame.

It sits between any value-producing datapath and the board's `an`/`seg`/`dp` pins.

---
 rtl/seg7_scan_mux.sv | 128 ++++++++++++
 tb/tb_seg7_scan_mux.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_mux.sv
// seg7_scan_mux: multiplexed common-anode hex display driver with double-buffered load,
// leading-zero blanking and 16-level PWM brightness; all outputs registered.
module seg7_scan_mux #(
    parameter int DIGITS = 4,
    parameter int REFRESH_DIV = 100000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  load,
    input  logic                  lz_en,
    input  logic [3:0]            brightness,
    output logic [DIGITS-1:0]     an,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic                  frame_done,
    output logic                  pending
);
    localparam int DW = $clog2(REFRESH_DIV);
    localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
    localparam logic [DW-1:0] DIV_MAX = DW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_MAX = IW'(DIGITS - 1);

    logic [DW-1:0]       div_cnt;
    logic [IW-1:0]       idx;
    logic [3:0]          pwm_cnt;
    logic [4*DIGITS-1:0] pend_val, act_val;
    logic [DIGITS-1:0]   pend_dp, act_dp, blank, an_next;
    logic                pend_lz, act_lz, adv, boundary, run;
    logic [3:0]          nib;
    logic [6:0]          glyph;

    assign adv      = div_cnt == DIV_MAX;
    assign boundary = adv && idx == IDX_MAX;

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt <= '0;
            idx     <= '0;
            pwm_cnt <= '0;
        end else begin
            div_cnt <= adv ? '0 : div_cnt + 1'b1;
            pwm_cnt <= pwm_cnt + 1'b1;
            if (adv) idx <= idx == IDX_MAX ? '0 : idx + 1'b1;
        end
    end

    // A load landing on the boundary bypasses the pending buffer straight into active.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_val   <= '0;
            pend_dp    <= '0;
            pend_lz    <= 1'b0;
            act_val    <= '0;
            act_dp     <= '0;
            act_lz     <= 1'b0;
            pending    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= boundary;
            if (boundary) begin
                pending <= 1'b0;
                if (load) begin
                    act_val <= value;
                    act_dp  <= dp_in;
                    act_lz  <= lz_en;
                end else if (pending) begin
                    act_val <= pend_val;
                    act_dp  <= pend_dp;
                    act_lz  <= pend_lz;
                end
            end else if (load) begin
                pend_val <= value;
                pend_dp  <= dp_in;
                pend_lz  <= lz_en;
                pending  <= 1'b1;
            end
        end
    end

    // Blanking runs from the leftmost digit and stops at the first visible one; digit 0 always shows.
    always_comb begin
        run   = act_lz;
        blank = '0;
        for (int i = DIGITS - 1; i > 0; i--) begin
            run      = run && act_val[4*i +: 4] == 4'h0 && !act_dp[i];
            blank[i] = run;
        end
    end

    assign nib = act_val[{idx, 2'b00} +: 4];

    always_comb begin
        case (nib)
            4'h0: glyph = 7'b1000000;
            4'h1: glyph = 7'b1111001;
            4'h2: glyph = 7'b0100100;
            4'h3: glyph = 7'b0110000;
            4'h4: glyph = 7'b0011001;
            4'h5: glyph = 7'b0010010;
            4'h6: glyph = 7'b0000010;
            4'h7: glyph = 7'b1111000;
            4'h8: glyph = 7'b0000000;
            4'h9: glyph = 7'b0010000;
            4'hA: glyph = 7'b0001000;
            4'hB: glyph = 7'b0000011;
            4'hC: glyph = 7'b1000110;
            4'hD: glyph = 7'b0100001;
            4'hE: glyph = 7'b0000110;
            default: glyph = 7'b0001110;
        endcase
    end

    assign an_next = (!blank[idx] && pwm_cnt <= brightness) ? ~(DIGITS'(1) << idx) : '1;

    always_ff @(posedge clk) begin
        if (reset) begin
            an  <= '1;
            seg <= 7'h7F;
            dp  <= 1'b1;
        end else begin
            an  <= an_next;
            seg <= blank[idx] ? 7'h7F : glyph;
            dp  <= blank[idx] | ~act_dp[idx];
        end
    end
endmodule

// File: tb/tb_seg7_scan_mux.sv
// tb_seg7_scan_mux: directed checks of scanning, double buffering, blanking, PWM and reset
// with DIGITS=4, REFRESH_DIV=4 (one frame = 16 cycles).
module tb_seg7_scan_mux;
    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic        load;
    logic        lz_en;
    logic [3:0]  brightness;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_done;
    logic        pending;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    seg7_scan_mux #(.DIGITS(4), .REFRESH_DIV(4)) dut (
        .clk(clk), .reset(reset), .value(value), .dp_in(dp_in), .load(load),
        .lz_en(lz_en), .brightness(brightness), .an(an), .seg(seg), .dp(dp),
        .frame_done(frame_done), .pending(pending)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic goto(input int n);
        while (cyc % 16 != n) tick();
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic lz);
        value = v;
        dp_in = d;
        lz_en = lz;
        load  = 1'b1;
        tick();
        load  = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; load = 1'b0; value = '0; dp_in = '0; lz_en = 1'b0; brightness = 4'd15;
        repeat (3) tick();
        total++; if (an !== 4'hF) begin bad++; $display("FAIL reset_an got=%b exp=1111", an); end
        total++; if (seg !== 7'h7F) begin bad++; $display("FAIL reset_seg got=%h exp=7f", seg); end
        total++; if (dp !== 1'b1) begin bad++; $display("FAIL reset_dp got=%b exp=1", dp); end
        total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL reset_fd got=%b exp=0", frame_done); end
        total++; if (pending !== 1'b0) begin bad++; $display("FAIL reset_pending got=%b exp=0", pending); end
        reset = 1'b0;
        cyc = 0;
    endtask

    task automatic test_scan();
        logic [3:0] ea;
        for (int k = 0; k < 32; k++) begin
            tick();
            ea = ~(4'b0001 << (((cyc - 1) / 4) % 4));
            total++; if (an !== ea) begin bad++; $display("FAIL scan_an cyc=%0d got=%b exp=%b", cyc, an, ea); end
            total++; if (seg !== 7'b1000000) begin bad++; $display("FAIL scan_seg cyc=%0d got=%b exp=1000000", cyc, seg); end
            total++; if (dp !== 1'b1) begin bad++; $display("FAIL scan_dp cyc=%0d got=%b exp=1", cyc, dp); end
            total++; if (frame_done !== (cyc % 16 == 0)) begin bad++; $display("FAIL scan_fd cyc=%0d got=%b exp=%b", cyc, frame_done, cyc % 16 == 0); end
        end
    endtask

    task automatic test_double_buffer();
        logic [6:0] e [4];
        int d;
        e = '{7'h0E, 7'h08, 7'h24, 7'h79};
        goto(5);
        do_load(16'h12AF, 4'b0000, 1'b0);
        total++; if (pending !== 1'b1) begin bad++; $display("FAIL db_pending_rise got=%b exp=1", pending); end
        while (cyc % 16 != 0) begin
            tick();
            total++; if (seg !== 7'b1000000) begin bad++; $display("FAIL db_hold_seg cyc=%0d got=%b exp=1000000", cyc, seg); end
            total++; if (pending !== (cyc % 16 != 0)) begin bad++; $display("FAIL db_pending cyc=%0d got=%b exp=%b", cyc, pending, cyc % 16 != 0); end
        end
        total++; if (frame_done !== 1'b1) begin bad++; $display("FAIL db_fd got=%b exp=1", frame_done); end
        for (int k = 0; k < 16; k++) begin
            tick();
            d = ((cyc - 1) / 4) % 4;
            total++; if (seg !== e[d]) begin bad++; $display("FAIL db_seg digit=%0d got=%b exp=%b", d, seg, e[d]); end
            total++; if (an !== ~(4'b0001 << d)) begin bad++; $display("FAIL db_an digit=%0d got=%b", d, an); end
            total++; if (pending !== 1'b0) begin bad++; $display("FAIL db_pending_after got=%b exp=0", pending); end
        end
    endtask

    task automatic test_lz();
        logic [6:0] e [4];
        logic [3:0] ea [4];
        logic       ed [4];
        int d;
        do_load(16'h0050, 4'b0000, 1'b1);
        goto(0);
        e  = '{7'h40, 7'h12, 7'h7F, 7'h7F};
        ea = '{4'b1110, 4'b1101, 4'b1111, 4'b1111};
        for (int k = 0; k < 16; k++) begin
            tick();
            d = ((cyc - 1) / 4) % 4;
            total++; if (seg !== e[d]) begin bad++; $display("FAIL lz1_seg digit=%0d got=%b exp=%b", d, seg, e[d]); end
            total++; if (an !== ea[d]) begin bad++; $display("FAIL lz1_an digit=%0d got=%b exp=%b", d, an, ea[d]); end
            total++; if (dp !== 1'b1) begin bad++; $display("FAIL lz1_dp digit=%0d got=%b exp=1", d, dp); end
        end
        do_load(16'h0000, 4'b0100, 1'b1);
        goto(0);
        e  = '{7'h40, 7'h40, 7'h40, 7'h7F};
        ea = '{4'b1110, 4'b1101, 4'b1011, 4'b1111};
        ed = '{1'b1, 1'b1, 1'b0, 1'b1};
        for (int k = 0; k < 16; k++) begin
            tick();
            d = ((cyc - 1) / 4) % 4;
            total++; if (seg !== e[d]) begin bad++; $display("FAIL lz2_seg digit=%0d got=%b exp=%b", d, seg, e[d]); end
            total++; if (an !== ea[d]) begin bad++; $display("FAIL lz2_an digit=%0d got=%b exp=%b", d, an, ea[d]); end
            total++; if (dp !== ed[d]) begin bad++; $display("FAIL lz2_dp digit=%0d got=%b exp=%b", d, dp, ed[d]); end
        end
    endtask

    task automatic test_brightness();
        logic [3:0] ea;
        int d, p, lows;
        do_load(16'h1234, 4'b0000, 1'b0);
        brightness = 4'd3;
        goto(0);
        lows = 0;
        for (int k = 0; k < 64; k++) begin
            tick();
            d = ((cyc - 1) / 4) % 4;
            p = (cyc - 1) % 16;
            ea = (p <= 3) ? ~(4'b0001 << d) : 4'b1111;
            if (an != 4'b1111) lows++;
            total++; if (an !== ea) begin bad++; $display("FAIL pwm_an cyc=%0d pwm=%0d got=%b exp=%b", cyc, p, an, ea); end
        end
        total++; if (lows !== 16) begin bad++; $display("FAIL pwm_duty got=%0d exp=16", lows); end
        brightness = 4'd15;
    endtask

    task automatic test_boundary();
        logic [6:0] e [4];
        int d;
        goto(15);
        do_load(16'hC0DE, 4'b0000, 1'b0);
        total++; if (pending !== 1'b0) begin bad++; $display("FAIL bnd_pending got=%b exp=0", pending); end
        total++; if (frame_done !== 1'b1) begin bad++; $display("FAIL bnd_fd got=%b exp=1", frame_done); end
        e = '{7'h06, 7'h21, 7'h40, 7'h46};
        for (int k = 0; k < 16; k++) begin
            tick();
            d = ((cyc - 1) / 4) % 4;
            total++; if (seg !== e[d]) begin bad++; $display("FAIL bnd_seg digit=%0d got=%b exp=%b", d, seg, e[d]); end
            total++; if (pending !== 1'b0) begin bad++; $display("FAIL bnd_pending_frame got=%b exp=0", pending); end
        end
    endtask

    task automatic test_back_to_back();
        logic [6:0] e [4];
        int d;
        goto(2);
        do_load(16'h1111, 4'b0000, 1'b0);
        goto(5);
        do_load(16'h0077, 4'b0000, 1'b0);
        total++; if (pending !== 1'b1) begin bad++; $display("FAIL b2b_pending got=%b exp=1", pending); end
        goto(0);
        e = '{7'h78, 7'h78, 7'h40, 7'h40};
        for (int k = 0; k < 16; k++) begin
            tick();
            d = ((cyc - 1) / 4) % 4;
            total++; if (seg !== e[d]) begin bad++; $display("FAIL b2b_seg digit=%0d got=%b exp=%b", d, seg, e[d]); end
        end
        total++; if (pending !== 1'b0) begin bad++; $display("FAIL b2b_pending_after got=%b exp=0", pending); end
    endtask

    task automatic test_mid_reset();
        goto(3);
        do_load(16'h9999, 4'b1111, 1'b0);
        total++; if (pending !== 1'b1) begin bad++; $display("FAIL mr_pending_pre got=%b exp=1", pending); end
        reset = 1'b1;
        tick();
        total++; if (an !== 4'hF) begin bad++; $display("FAIL mr_an got=%b exp=1111", an); end
        total++; if (seg !== 7'h7F) begin bad++; $display("FAIL mr_seg got=%h exp=7f", seg); end
        total++; if (dp !== 1'b1) begin bad++; $display("FAIL mr_dp got=%b exp=1", dp); end
        total++; if (pending !== 1'b0) begin bad++; $display("FAIL mr_pending got=%b exp=0", pending); end
        reset = 1'b0;
        cyc = 0;
        for (int k = 0; k < 32; k++) begin
            tick();
            total++; if (seg !== 7'b1000000 || dp !== 1'b1) begin bad++; $display("FAIL mr_seg_after cyc=%0d got=%b/%b exp=1000000/1", cyc, seg, dp); end
            total++; if (an !== ~(4'b0001 << (((cyc - 1) / 4) % 4))) begin bad++; $display("FAIL mr_an_after cyc=%0d got=%b", cyc, an); end
            total++; if (pending !== 1'b0) begin bad++; $display("FAIL mr_pending_after cyc=%0d got=%b exp=0", cyc, pending); end
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_double_buffer();
        test_lz();
        test_brightness();
        test_boundary();
        test_back_to_back();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
